// File: rtl/mac_kbd_pkg.sv
// Shared types and protocol constants for the Mac Plus keyboard host link.
// Covers the state encoding, the command bytes and the reply bytes.
package mac_kbd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        TX,
        TURN,
        WAIT,
        RX,
        ERR
    } kbd_state_t;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL = 8'h7B;
    localparam logic [7:0] RSP_ACK  = 8'h7D;
    localparam logic [7:0] RSP_NAK  = 8'h77;

    localparam int TMO_W = 21;

endpackage

// File: rtl/kbd_line_sync.sv
// Two-flop synchronizers for the keyboard clock and data pads.
// Also produces enable-qualified rise/fall pulses of the synchronized clock.
module kbd_line_sync (
    input  logic clk,
    input  logic _systemReset,
    input  logic clk8_en_p,
    input  logic i_kbd_clk,
    input  logic i_kbd_dat,
    output logic o_dat,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_clk_s;
    logic [1:0] r_dat_s;
    logic       r_clk_d;

    // Reset to the idle-high line level so release never looks like an edge
    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) begin
            r_clk_s <= 2'b11;
            r_dat_s <= 2'b11;
            r_clk_d <= 1'b1;
        end else if (clk8_en_p) begin
            r_clk_s <= {r_clk_s[0], i_kbd_clk};
            r_dat_s <= {r_dat_s[0], i_kbd_dat};
            r_clk_d <= r_clk_s[1];
        end
    end

    assign o_dat  = r_dat_s[1];
    assign o_rise = clk8_en_p & r_clk_s[1] & ~r_clk_d;
    assign o_fall = clk8_en_p & ~r_clk_s[1] & r_clk_d;

endmodule

// File: rtl/mac_kbd_host.sv
// Host (Mac) end of the M0110 keyboard link: sends one command byte
// on the device clock, then receives one reply byte or reports a timeout.
module mac_kbd_host
    import mac_kbd_pkg::*;
#(
    parameter int unsigned TURN_DLY    = 16,
    parameter int unsigned RSP_TIMEOUT = 2000000,
    parameter int unsigned BIT_TIMEOUT = 8000
) (
    input  logic       clk,
    input  logic       _systemReset,
    input  logic       clk8_en_p,
    input  logic       kbd_clk_i,
    input  logic       kbd_dat_i,
    output logic       kbd_dat_oe,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    output logic       rsp_err,
    output logic       busy
);

    localparam logic [TMO_W-1:0] TURN_LIM = TMO_W'(TURN_DLY - 1);
    localparam logic [TMO_W-1:0] RSP_LIM  = TMO_W'(RSP_TIMEOUT);
    localparam logic [TMO_W-1:0] BIT_LIM  = TMO_W'(BIT_TIMEOUT);

    kbd_state_t       r_state;
    logic [7:0]       r_shift;
    logic [3:0]       r_bitcnt;
    logic [TMO_W-1:0] r_tmo;
    logic             r_oe;
    logic [7:0]       r_rsp_data;
    logic             r_rsp_valid;
    logic             r_rsp_err;

    logic             w_dat;
    logic             w_rise;
    logic             w_fall;

    kbd_state_t       w_nstate;
    logic [7:0]       w_nshift;
    logic [3:0]       w_nbit;
    logic             w_noe;
    logic             w_rsp_set;
    logic             w_rsp_err;
    logic [7:0]       w_rsp_byte;

    kbd_line_sync u_sync (
        .clk          (clk),
        ._systemReset (_systemReset),
        .clk8_en_p    (clk8_en_p),
        .i_kbd_clk    (kbd_clk_i),
        .i_kbd_dat    (kbd_dat_i),
        .o_dat        (w_dat),
        .o_rise       (w_rise),
        .o_fall       (w_fall)
    );

    always_comb begin
        w_nstate   = r_state;
        w_nshift   = r_shift;
        w_nbit     = r_bitcnt;
        w_noe      = r_oe;
        w_rsp_set  = 1'b0;
        w_rsp_err  = 1'b0;
        w_rsp_byte = r_rsp_data;
        unique case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_nstate = REQ;
                    w_nshift = cmd_data;
                    w_nbit   = 4'd0;
                    w_noe    = 1'b1;
                end
            end
            REQ: begin
                if (w_fall) begin
                    w_noe    = ~r_shift[7];
                    w_nshift = {r_shift[6:0], 1'b0};
                    w_nstate = TX;
                end else if (r_tmo >= RSP_LIM) begin
                    w_nstate = ERR;
                end
            end
            TX: begin
                if (w_fall) begin
                    w_noe    = ~r_shift[7];
                    w_nshift = {r_shift[6:0], 1'b0};
                end else if (w_rise) begin
                    w_nbit = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) w_nstate = TURN;
                end else if (r_tmo >= BIT_LIM) begin
                    w_nstate = ERR;
                end
            end
            TURN: begin
                if (r_tmo >= TURN_LIM) begin
                    w_noe    = 1'b0;
                    w_nbit   = 4'd0;
                    w_nstate = WAIT;
                end
            end
            WAIT: begin
                if (w_rise) begin
                    w_nshift = {r_shift[6:0], w_dat};
                    w_nbit   = 4'd1;
                    w_nstate = RX;
                end else if (r_tmo >= RSP_LIM) begin
                    w_nstate = ERR;
                end
            end
            RX: begin
                if (w_rise) begin
                    w_nshift = {r_shift[6:0], w_dat};
                    w_nbit   = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd7) begin
                        w_nstate   = IDLE;
                        w_rsp_set  = 1'b1;
                        w_rsp_byte = {r_shift[6:0], w_dat};
                    end
                end else if (r_tmo >= BIT_LIM) begin
                    w_nstate = ERR;
                end
            end
            ERR: begin
                w_noe      = 1'b0;
                w_nstate   = IDLE;
                w_rsp_set  = 1'b1;
                w_rsp_err  = 1'b1;
                w_rsp_byte = RSP_NULL;
            end
            default: begin
                w_noe    = 1'b0;
                w_nstate = IDLE;
            end
        endcase
        // Let go of the line the moment a timeout is declared
        if (w_nstate == ERR) w_noe = 1'b0;
    end

    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) begin
            r_state  <= IDLE;
            r_shift  <= 8'h00;
            r_bitcnt <= 4'd0;
            r_tmo    <= '0;
            r_oe     <= 1'b0;
        end else if (clk8_en_p) begin
            r_state  <= w_nstate;
            r_shift  <= w_nshift;
            r_bitcnt <= w_nbit;
            r_oe     <= w_noe;
            if (w_nstate != r_state || w_rise || w_fall)
                r_tmo <= '0;
            else if (r_tmo != '1)
                r_tmo <= r_tmo + 1'b1;
        end
    end

    // Reply strobe is one system clock wide even though the FSM runs at 8 MHz
    always_ff @(posedge clk or negedge _systemReset) begin
        if (!_systemReset) begin
            r_rsp_data  <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (clk8_en_p && w_rsp_set) begin
                r_rsp_data  <= w_rsp_byte;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_rsp_err;
            end
        end
    end

    assign kbd_dat_oe = r_oe;
    assign cmd_ready  = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign rsp_data   = r_rsp_data;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_mac_kbd_host.sv
// Directed bench for mac_kbd_host with a simple M0110 device model
// using shortened bit periods and timeouts.
module tb_mac_kbd_host;
    import mac_kbd_pkg::*;

    localparam int TD = 16;
    localparam int RT = 400;
    localparam int BT = 100;
    localparam int HP = 20;

    logic       clk = 1'b0;
    logic       _systemReset = 1'b0;
    logic       clk8_en_p = 1'b0;
    logic       kbd_clk_i = 1'b1;
    logic       dev_dat = 1'b1;
    logic       kbd_dat_i;
    logic       kbd_dat_oe;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_err;
    logic       busy;

    int         n_chk = 0;
    int         n_err = 0;
    int         rsp_cnt = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_err = 1'b0;
    logic [7:0] got;
    int         c0;

    assign kbd_dat_i = dev_dat & ~kbd_dat_oe;

    mac_kbd_host #(
        .TURN_DLY    (TD),
        .RSP_TIMEOUT (RT),
        .BIT_TIMEOUT (BT)
    ) dut (
        .clk          (clk),
        ._systemReset (_systemReset),
        .clk8_en_p    (clk8_en_p),
        .kbd_clk_i    (kbd_clk_i),
        .kbd_dat_i    (kbd_dat_i),
        .kbd_dat_oe   (kbd_dat_oe),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .rsp_data     (rsp_data),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) clk8_en_p = ~clk8_en_p;

    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cnt = rsp_cnt + 1;
            last_data = rsp_data;
            last_err = rsp_err;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic wait_line(input logic lvl, input int max, input string tag);
        int i = 0;
        while (kbd_dat_i !== lvl && i < max) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(kbd_dat_i), 32'(lvl));
    endtask

    task automatic wait_rsp(input int base, input int max, input string tag);
        int i = 0;
        while (rsp_cnt == base && i < max) begin
            @(negedge clk);
            i++;
        end
        chk(tag, rsp_cnt, base + 1);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        int i = 0;
        @(negedge clk);
        cmd_data = b;
        cmd_valid = 1'b1;
        while (!busy && i < 10) begin
            @(negedge clk);
            i++;
        end
        cmd_valid = 1'b0;
        chk("accept", 32'(busy), 32'd1);
    endtask

    task automatic dev_tx(input int n, output logic [7:0] bits);
        bits = 8'h00;
        wait_line(1'b0, 50, "req_low");
        tick(10);
        for (int i = 0; i < n; i++) begin
            kbd_clk_i = 1'b0;
            tick(HP);
            kbd_clk_i = 1'b1;
            bits = {bits[6:0], kbd_dat_i};
            tick(HP);
        end
    endtask

    task automatic dev_rx(input logic [7:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            kbd_clk_i = 1'b0;
            dev_dat = r[7-i];
            tick(HP);
            kbd_clk_i = 1'b1;
            tick(HP);
        end
        dev_dat = 1'b1;
    endtask

    initial begin
        #23;
        chk("rst_oe", 32'(kbd_dat_oe), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        tick(2);
        _systemReset = 1'b1;
        tick(4);

        // model query, full round trip
        c0 = rsp_cnt;
        send_cmd(CMD_MODEL);
        dev_tx(8, got);
        chk("t1_bits", 32'(got), 32'h16);
        wait_line(1'b1, 200, "t1_rel");
        tick(10);
        dev_rx(8'h0B, 8);
        tick(10);
        chk("t1_cnt", rsp_cnt, c0 + 1);
        chk("t1_data", 32'(last_data), 32'h0B);
        chk("t1_err", 32'(last_err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // silent device after command
        c0 = rsp_cnt;
        send_cmd(CMD_INQUIRY);
        dev_tx(8, got);
        chk("t2_bits", 32'(got), 32'h10);
        wait_rsp(c0, 2 * (RT + 100), "t2_rsp");
        chk("t2_data", 32'(last_data), 32'h7B);
        chk("t2_err", 32'(last_err), 32'd1);
        chk("t2_oe", 32'(kbd_dat_oe), 32'd0);

        // device stops after 3 command bits
        c0 = rsp_cnt;
        send_cmd(CMD_TEST);
        dev_tx(3, got);
        chk("t3_bits", 32'(got[2:0]), 32'b001);
        wait_rsp(c0, 2 * (BT + 50), "t3_rsp");
        chk("t3_data", 32'(last_data), 32'h7B);
        chk("t3_err", 32'(last_err), 32'd1);
        chk("t3_oe", 32'(kbd_dat_oe), 32'd0);
        @(negedge clk);
        chk("t3_ready", 32'(cmd_ready), 32'd1);
        tick(10);

        // second request while busy is dropped
        c0 = rsp_cnt;
        send_cmd(CMD_MODEL);
        cmd_data = CMD_INSTANT;
        cmd_valid = 1'b1;
        dev_tx(8, got);
        cmd_valid = 1'b0;
        chk("t4_bits", 32'(got), 32'h16);
        wait_line(1'b1, 200, "t4_rel");
        tick(10);
        dev_rx(RSP_ACK, 8);
        tick(20);
        chk("t4_cnt", rsp_cnt, c0 + 1);
        chk("t4_data", 32'(last_data), 32'h7D);
        chk("t4_busy", 32'(busy), 32'd0);

        // reset while the line is pulled low
        send_cmd(CMD_INQUIRY);
        wait_line(1'b0, 50, "t5a_low");
        @(negedge clk);
        #2 _systemReset = 1'b0;
        #1;
        chk("t5a_oe", 32'(kbd_dat_oe), 32'd0);
        chk("t5a_line", 32'(kbd_dat_i), 32'd1);
        tick(2);
        _systemReset = 1'b1;
        tick(4);

        // reset during reply bit 4
        c0 = rsp_cnt;
        send_cmd(CMD_INQUIRY);
        dev_tx(8, got);
        wait_line(1'b1, 200, "t5_rel");
        tick(10);
        dev_rx(8'hA5, 4);
        kbd_clk_i = 1'b0;
        tick(5);
        #2 _systemReset = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_oe", 32'(kbd_dat_oe), 32'd0);
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        tick(2);
        kbd_clk_i = 1'b1;
        _systemReset = 1'b1;
        tick(20);
        chk("t5_nopulse", rsp_cnt, c0);
        send_cmd(CMD_TEST);
        dev_tx(8, got);
        chk("t5_bits", 32'(got), 32'h36);
        wait_line(1'b1, 200, "t5b_rel");
        tick(10);
        dev_rx(8'h5A, 8);
        tick(10);
        chk("t5_cnt", rsp_cnt, c0 + 1);
        chk("t5_data", 32'(last_data), 32'h5A);
        chk("t5_err", 32'(last_err), 32'd0);

        // clock glitches while idle
        c0 = rsp_cnt;
        repeat (4) begin
            @(negedge clk);
            kbd_clk_i = 1'b0;
            @(negedge clk);
            kbd_clk_i = 1'b1;
            tick(3);
            chk("t6_busy", 32'(busy), 32'd0);
        end
        tick(10);
        chk("t6_cnt", rsp_cnt, c0);
        chk("t6_oe", 32'(kbd_dat_oe), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
